// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: field widths, EXE command encodings and the
// ID/EXE stage payload.
package pipe_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CMD_W  = 4;

    // EXE stage ALU commands
    typedef enum logic [CMD_W-1:0] {
        EXE_NOP = 4'd0,
        EXE_MOV = 4'd1,
        EXE_MVN = 4'd9,
        EXE_ADD = 4'd2,
        EXE_ADC = 4'd3,
        EXE_SUB = 4'd4,
        EXE_SBC = 4'd5,
        EXE_AND = 4'd6,
        EXE_ORR = 4'd7,
        EXE_EOR = 4'd8
    } exe_cmd_e;

    // Everything the EXE stage and forwarding unit see from this register
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [REG_W-1:0]  src1;
        logic [REG_W-1:0]  src2;
        logic [REG_W-1:0]  st_src;
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] val1;
        logic [DATA_W-1:0] val2;
        logic [DATA_W-1:0] st_val;
        logic [CMD_W-1:0]  cmd;
        logic              wb_en;
        logic              mem_r_en;
        logic              mem_w_en;
    } id_exe_t;

    // A bubble is an all-zero stage
    localparam id_exe_t BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
// Flags when the load currently in EXE writes a register that the
// instruction in ID reads; forwarding cannot cover that distance.
// Ports:
//   exe_valid/exe_mem_r_en/exe_wb_en/exe_dest : registered EXE stage state
//   id_valid, id_src1/2, id_st_src, id_uses_* : ID instruction operand usage
//   hz_c                                      : hazard present this cycle
module load_use_detect
    import pipe_pkg::*;
(
    input  logic             exe_valid,
    input  logic             exe_mem_r_en,
    input  logic             exe_wb_en,
    input  logic [REG_W-1:0] exe_dest,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic [REG_W-1:0] id_st_src,
    input  logic             id_uses_src1,
    input  logic             id_uses_src2,
    input  logic             id_uses_st,
    output logic             hz_c
);

    logic load_in_exe;
    logic id_reads_dest;

    // r0 is hard-wired, so a load targeting it never blocks anyone
    assign load_in_exe   = exe_valid & exe_mem_r_en & exe_wb_en & (exe_dest != '0);
    assign id_reads_dest = (id_uses_src1 & (id_src1   == exe_dest))
                         | (id_uses_src2 & (id_src2   == exe_dest))
                         | (id_uses_st   & (id_st_src == exe_dest));
    assign hz_c          = load_in_exe & id_valid & id_reads_dest;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with load-use interlock.
// Captures the decoded ID instruction, inserts a single bubble on a load-use
// hazard, honours freeze (memory stall) and flush (taken branch), and keeps a
// saturating count of interlock bubbles.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   freeze, flush     : global hold / kill of the ID instruction
//   id_*              : decoded ID instruction
//   stall_o           : hold PC and IF/ID this cycle
//   exe_*             : registered stage contents
//   bubble_cnt        : saturating load-use bubble count
module id_exe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [REG_W-1:0]  id_src1,
    input  logic [REG_W-1:0]  id_src2,
    input  logic [REG_W-1:0]  id_st_src,
    input  logic [REG_W-1:0]  id_dest,
    input  logic              id_uses_src1,
    input  logic              id_uses_src2,
    input  logic              id_uses_st,
    input  logic [DATA_W-1:0] id_val1,
    input  logic [DATA_W-1:0] id_val2,
    input  logic [DATA_W-1:0] id_st_val,
    input  logic [CMD_W-1:0]  id_exe_cmd,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    output logic              stall_o,
    output logic              exe_valid,
    output logic [DATA_W-1:0] exe_pc,
    output logic [REG_W-1:0]  exe_src1,
    output logic [REG_W-1:0]  exe_src2,
    output logic [REG_W-1:0]  exe_st_src,
    output logic [REG_W-1:0]  exe_dest,
    output logic [DATA_W-1:0] exe_val1,
    output logic [DATA_W-1:0] exe_val2,
    output logic [DATA_W-1:0] exe_st_val,
    output logic [CMD_W-1:0]  exe_cmd,
    output logic              exe_wb_en,
    output logic              exe_mem_r_en,
    output logic              exe_mem_w_en,
    output logic [CNT_W-1:0]  bubble_cnt
);

    id_exe_t          stage_q;
    id_exe_t          stage_d;
    id_exe_t          id_stage;
    logic [CNT_W-1:0] cnt_d;
    logic             hz;

    load_use_detect u_load_use_detect (
        .exe_valid    (stage_q.valid),
        .exe_mem_r_en (stage_q.mem_r_en),
        .exe_wb_en    (stage_q.wb_en),
        .exe_dest     (stage_q.dest),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_st_src    (id_st_src),
        .id_uses_src1 (id_uses_src1),
        .id_uses_src2 (id_uses_src2),
        .id_uses_st   (id_uses_st),
        .hz_c         (hz)
    );

    // Freeze already holds upstream, and flush discards the ID slot anyway
    assign stall_o = hz & ~freeze & ~flush;

    // Pack the ID inputs into the stage payload
    always_comb begin
        id_stage          = BUBBLE;
        id_stage.valid    = 1'b1;
        id_stage.pc       = id_pc;
        id_stage.src1     = id_src1;
        id_stage.src2     = id_src2;
        id_stage.st_src   = id_st_src;
        id_stage.dest     = id_dest;
        id_stage.val1     = id_val1;
        id_stage.val2     = id_val2;
        id_stage.st_val   = id_st_val;
        id_stage.cmd      = id_exe_cmd;
        id_stage.wb_en    = id_wb_en;
        id_stage.mem_r_en = id_mem_r_en;
        id_stage.mem_w_en = id_mem_w_en;
    end

    // Next-state priority: flush, freeze, hazard bubble, normal load
    always_comb begin
        stage_d = stage_q;
        cnt_d   = bubble_cnt;
        if (flush) begin
            stage_d = BUBBLE;
        end else if (freeze) begin
            stage_d = stage_q;
        end else if (hz) begin
            stage_d = BUBBLE;
            if (bubble_cnt != {CNT_W{1'b1}}) begin
                cnt_d = bubble_cnt + CNT_W'(1);
            end
        end else if (id_valid) begin
            stage_d = id_stage;
        end else begin
            stage_d = BUBBLE;
        end
    end

    // Stage register and bubble counter
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q    <= BUBBLE;
            bubble_cnt <= '0;
        end else begin
            stage_q    <= stage_d;
            bubble_cnt <= cnt_d;
        end
    end

    assign exe_valid    = stage_q.valid;
    assign exe_pc       = stage_q.pc;
    assign exe_src1     = stage_q.src1;
    assign exe_src2     = stage_q.src2;
    assign exe_st_src   = stage_q.st_src;
    assign exe_dest     = stage_q.dest;
    assign exe_val1     = stage_q.val1;
    assign exe_val2     = stage_q.val2;
    assign exe_st_val   = stage_q.st_val;
    assign exe_cmd      = stage_q.cmd;
    assign exe_wb_en    = stage_q.wb_en;
    assign exe_mem_r_en = stage_q.mem_r_en;
    assign exe_mem_w_en = stage_q.mem_w_en;

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Testbench for id_exe_stage_reg: directed table, random stimulus against a
// reference model, and a counter saturation sequence on a narrow-counter copy.
module tb_id_exe_stage_reg;
    import pipe_pkg::*;

    typedef struct packed {
        logic        rst, freeze, flush, valid;
        logic [31:0] pc;
        logic [4:0]  src1, src2, st_src, dest;
        logic        u1, u2, ust;
        logic [31:0] val1, val2, st_val;
        logic [3:0]  cmd;
        logic        wb, mr, mw;
    } in_t;

    typedef struct {
        in_t  i;
        bit   chk_stall;
        bit   exp_stall;
        bit   exp_valid;
        int   exp_dest;
        int   exp_src2;
        int   exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    in_t cur;
    logic stall_o, stall_s;
    id_exe_t act, act_s;
    logic [15:0] bubble_cnt;
    logic [1:0]  bubble_cnt_s;

    id_exe_stage_reg #(.CNT_W(16)) dut (
        .clk(clk), .rst(cur.rst), .freeze(cur.freeze), .flush(cur.flush),
        .id_valid(cur.valid), .id_pc(cur.pc), .id_src1(cur.src1), .id_src2(cur.src2),
        .id_st_src(cur.st_src), .id_dest(cur.dest), .id_uses_src1(cur.u1),
        .id_uses_src2(cur.u2), .id_uses_st(cur.ust), .id_val1(cur.val1),
        .id_val2(cur.val2), .id_st_val(cur.st_val), .id_exe_cmd(cur.cmd),
        .id_wb_en(cur.wb), .id_mem_r_en(cur.mr), .id_mem_w_en(cur.mw),
        .stall_o(stall_o), .exe_valid(act.valid), .exe_pc(act.pc),
        .exe_src1(act.src1), .exe_src2(act.src2), .exe_st_src(act.st_src),
        .exe_dest(act.dest), .exe_val1(act.val1), .exe_val2(act.val2),
        .exe_st_val(act.st_val), .exe_cmd(act.cmd), .exe_wb_en(act.wb_en),
        .exe_mem_r_en(act.mem_r_en), .exe_mem_w_en(act.mem_w_en),
        .bubble_cnt(bubble_cnt)
    );

    id_exe_stage_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(cur.rst), .freeze(cur.freeze), .flush(cur.flush),
        .id_valid(cur.valid), .id_pc(cur.pc), .id_src1(cur.src1), .id_src2(cur.src2),
        .id_st_src(cur.st_src), .id_dest(cur.dest), .id_uses_src1(cur.u1),
        .id_uses_src2(cur.u2), .id_uses_st(cur.ust), .id_val1(cur.val1),
        .id_val2(cur.val2), .id_st_val(cur.st_val), .id_exe_cmd(cur.cmd),
        .id_wb_en(cur.wb), .id_mem_r_en(cur.mr), .id_mem_w_en(cur.mw),
        .stall_o(stall_s), .exe_valid(act_s.valid), .exe_pc(act_s.pc),
        .exe_src1(act_s.src1), .exe_src2(act_s.src2), .exe_st_src(act_s.st_src),
        .exe_dest(act_s.dest), .exe_val1(act_s.val1), .exe_val2(act_s.val2),
        .exe_st_val(act_s.st_val), .exe_cmd(act_s.cmd), .exe_wb_en(act_s.wb_en),
        .exe_mem_r_en(act_s.mem_r_en), .exe_mem_w_en(act_s.mem_w_en),
        .bubble_cnt(bubble_cnt_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: what EXE should hold and how many bubbles ever occurred
    id_exe_t m_stage;
    int      m_bubbles;

    function automatic bit model_hazard(input in_t x);
        logic [4:0] idx[3];
        bit         rd[3];
        bit         hit = 0;
        if (!(m_stage.valid && m_stage.mem_r_en && m_stage.wb_en && m_stage.dest != 0 && x.valid))
            return 0;
        idx = '{x.src1, x.src2, x.st_src};
        rd  = '{x.u1, x.u2, x.ust};
        for (int k = 0; k < 3; k++)
            if (rd[k] && idx[k] == m_stage.dest) hit = 1;
        return hit;
    endfunction

    function automatic id_exe_t as_stage(input in_t x);
        id_exe_t s;
        s = '{valid: 1'b1, pc: x.pc, src1: x.src1, src2: x.src2, st_src: x.st_src,
              dest: x.dest, val1: x.val1, val2: x.val2, st_val: x.st_val, cmd: x.cmd,
              wb_en: x.wb, mem_r_en: x.mr, mem_w_en: x.mw};
        return s;
    endfunction

    // One cycle: apply inputs, check stall, clock, check stage against model
    task automatic step(input in_t x, output bit got_stall);
        bit hz;
        cur = x;
        #1;
        hz = model_hazard(x);
        got_stall = stall_o;
        if (!x.rst) begin
            check("stall_o", 160'(stall_o), 160'(hz && !x.freeze && !x.flush));
            check("stall_o_sat", 160'(stall_s), 160'(hz && !x.freeze && !x.flush));
        end
        if (x.rst) begin
            m_stage = '0; m_bubbles = 0;
        end else if (x.flush) begin
            m_stage = '0;
        end else if (x.freeze) begin
            m_stage = m_stage;
        end else if (hz) begin
            m_stage = '0; m_bubbles++;
        end else begin
            m_stage = x.valid ? as_stage(x) : id_exe_t'('0);
        end
        @(posedge clk);
        #1;
        check("exe_stage", 160'(act), 160'(m_stage));
        check("bubble_cnt", 160'(bubble_cnt), 160'((m_bubbles > 65535) ? 65535 : m_bubbles));
        check("bubble_cnt_sat", 160'(bubble_cnt_s), 160'((m_bubbles > 3) ? 3 : m_bubbles));
    endtask

    function automatic in_t op_add(int s1, int s2, int d);
        in_t x = '0;
        x.valid = 1; x.src1 = 5'(s1); x.src2 = 5'(s2); x.dest = 5'(d);
        x.u1 = 1; x.u2 = 1; x.wb = 1; x.cmd = EXE_ADD;
        x.pc = 32'h1000 + 32'(d) * 4; x.val1 = 32'h10; x.val2 = 32'h20; x.st_val = 32'h30;
        return x;
    endfunction

    function automatic in_t op_ld(int s1, int d, bit wb);
        in_t x = op_add(s1, 0, d);
        x.u2 = 0; x.mr = 1; x.wb = wb;
        return x;
    endfunction

    function automatic in_t op_st(int s1, int st);
        in_t x = op_add(s1, 0, 0);
        x.u2 = 0; x.st_src = 5'(st); x.ust = 1; x.wb = 0; x.mw = 1;
        return x;
    endfunction

    function automatic vec_t row(bit r, bit fz, bit fl, in_t i, bit cs, bit es,
                                 bit ev, int ed, int es2, int ec);
        vec_t v;
        i.rst = r; i.freeze = fz; i.flush = fl;
        v.i = i; v.chk_stall = cs; v.exp_stall = es; v.exp_valid = ev;
        v.exp_dest = ed; v.exp_src2 = es2; v.exp_cnt = ec;
        return v;
    endfunction

    vec_t tbl[$];
    bit   s;
    in_t  x;
    in_t  inv;

    initial begin
        cur = '0;
        cur.rst = 1;
        m_stage = '0;
        m_bubbles = 0;
        inv = op_add(1, 2, 3);
        inv.valid = 0;

        //             rst fz fl instruction          cs st  v  dest src2 cnt
        tbl.push_back(row(1, 0, 0, op_add(3, 4, 5),    0, 0, 0, 0,  0, 0)); // reset with live ID
        tbl.push_back(row(1, 0, 0, op_add(3, 4, 5),    0, 0, 0, 0,  0, 0));
        tbl.push_back(row(0, 0, 0, op_add(3, 4, 5),    1, 0, 1, 5,  4, 0)); // pass-through
        tbl.push_back(row(0, 0, 0, op_ld(1, 7, 1),     1, 0, 1, 7,  0, 0)); // load r7
        tbl.push_back(row(0, 0, 0, op_add(3, 7, 8),    1, 1, 0, 0,  0, 1)); // use r7 -> bubble
        tbl.push_back(row(0, 0, 0, op_add(3, 7, 8),    1, 0, 1, 8,  7, 1)); // held add enters
        tbl.push_back(row(0, 0, 0, op_ld(1, 9, 1),     1, 0, 1, 9,  0, 1)); // load r9
        tbl.push_back(row(0, 0, 0, op_st(2, 9),        1, 1, 0, 0,  0, 2)); // store data r9
        tbl.push_back(row(0, 0, 0, op_st(2, 9),        1, 0, 1, 0,  0, 2));
        tbl.push_back(row(0, 0, 0, op_ld(1, 0, 1),     1, 0, 1, 0,  0, 2)); // load r0
        tbl.push_back(row(0, 0, 0, op_add(0, 0, 6),    1, 0, 1, 6,  0, 2)); // use r0: no bubble
        tbl.push_back(row(0, 0, 0, op_ld(1, 7, 1),     1, 0, 1, 7,  0, 2));
        tbl.push_back(row(0, 1, 0, op_add(7, 2, 10),   1, 0, 1, 7,  0, 2)); // freeze during hazard
        tbl.push_back(row(0, 1, 0, op_add(7, 2, 10),   1, 0, 1, 7,  0, 2));
        tbl.push_back(row(0, 1, 0, op_add(7, 2, 10),   1, 0, 1, 7,  0, 2));
        tbl.push_back(row(0, 0, 0, op_add(7, 2, 10),   1, 1, 0, 0,  0, 3)); // release -> stall
        tbl.push_back(row(0, 0, 0, op_add(7, 2, 10),   1, 0, 1, 10, 2, 3));
        tbl.push_back(row(0, 0, 0, op_ld(1, 11, 1),    1, 0, 1, 11, 0, 3));
        tbl.push_back(row(0, 0, 1, op_add(11, 0, 12),  1, 0, 0, 0,  0, 3)); // flush beats hazard
        tbl.push_back(row(0, 0, 0, op_add(4, 5, 13),   1, 0, 1, 13, 5, 3));
        tbl.push_back(row(0, 0, 0, op_ld(1, 14, 0),    1, 0, 1, 14, 0, 3)); // load, no writeback
        tbl.push_back(row(0, 0, 0, op_add(14, 14, 15), 1, 0, 1, 15, 14, 3));
        tbl.push_back(row(0, 0, 0, op_ld(1, 16, 1),    1, 0, 1, 16, 0, 3));
        tbl.push_back(row(1, 0, 0, op_add(16, 0, 17),  0, 0, 0, 0,  0, 0)); // reset mid-stall
        tbl.push_back(row(0, 0, 0, op_add(16, 0, 17),  1, 0, 1, 17, 0, 0));
        tbl.push_back(row(0, 0, 0, inv,                1, 0, 0, 0,  0, 0)); // invalid ID

        @(posedge clk);
        #1;
        foreach (tbl[n]) begin
            step(tbl[n].i, s);
            if (tbl[n].chk_stall) check($sformatf("tbl%0d_stall", n), 160'(s), 160'(tbl[n].exp_stall));
            check($sformatf("tbl%0d_valid", n), 160'(act.valid), 160'(tbl[n].exp_valid));
            check($sformatf("tbl%0d_dest", n), 160'(act.dest), 160'(tbl[n].exp_dest));
            check($sformatf("tbl%0d_src2", n), 160'(act.src2), 160'(tbl[n].exp_src2));
            check($sformatf("tbl%0d_cnt", n), 160'(bubble_cnt), 160'(tbl[n].exp_cnt));
        end

        // Randomized traffic over a tiny register set so hazards are frequent
        for (int n = 0; n < 400; n++) begin
            x        = '0;
            x.rst    = ($urandom_range(0, 59) == 0);
            x.freeze = ($urandom_range(0, 6) == 0);
            x.flush  = ($urandom_range(0, 9) == 0);
            x.valid  = ($urandom_range(0, 7) != 0);
            x.pc     = $urandom;
            x.src1   = 5'($urandom_range(0, 3));
            x.src2   = 5'($urandom_range(0, 3));
            x.st_src = 5'($urandom_range(0, 3));
            x.dest   = 5'($urandom_range(0, 3));
            x.u1     = 1'($urandom_range(0, 1));
            x.u2     = 1'($urandom_range(0, 1));
            x.ust    = 1'($urandom_range(0, 1));
            x.val1   = $urandom;
            x.val2   = $urandom;
            x.st_val = $urandom;
            x.cmd    = 4'($urandom_range(0, 15));
            x.wb     = ($urandom_range(0, 4) != 0);
            x.mr     = ($urandom_range(0, 4) < 2);
            x.mw     = 1'($urandom_range(0, 1));
            step(x, s);
        end

        // Saturation: five load-use bubbles on the 2-bit counter
        x = op_add(1, 2, 3);
        x.rst = 1;
        step(x, s);
        for (int n = 0; n < 5; n++) begin
            step(op_ld(1, 7, 1), s);
            step(op_add(3, 7, 8), s);
            step(op_add(3, 7, 8), s);
        end
        check("sat_cnt_after_5", 160'(bubble_cnt_s), 160'(3));
        check("wide_cnt_after_5", 160'(bubble_cnt), 160'(5));
        step(op_ld(1, 7, 1), s);
        step(op_add(3, 7, 8), s);
        check("sat_cnt_holds", 160'(bubble_cnt_s), 160'(3));
        check("wide_cnt_after_6", 160'(bubble_cnt), 160'(6));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- ID/EXE pipeline register with an integrated load-use interlock.
- Captures decoded instructions from ID and presents src1, src2, ST_src and dest to the EXE stage and forwarding unit.
- Inserts one bubble when the load in EXE feeds the instruction in ID, since forwarding cannot cover a load-to-use distance of 1.
- Honours a global freeze (memory wait) and flush (taken branch), and counts inserted bubbles.

Parameters:
DATA_W, 32, width of operand values and PC
REG_W, 5, register index width
CMD_W, 4, EXE command width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset: synchronous, active-high
freeze  in  1  hold all state (memory stall)
flush  in  1  kill the ID instruction (taken branch)
id_valid  in  1  ID slot holds a real instruction
id_pc  in  DATA_W  PC+4 of ID instruction
id_src1, id_src2, id_st_src, id_dest  in  REG_W  register indices
id_uses_src1, id_uses_src2, id_uses_st  in  1  ID instruction actually reads that index
id_val1, id_val2, id_st_val  in  DATA_W  register-file read values
id_exe_cmd  in  CMD_W  ALU command
id_wb_en, id_mem_r_en, id_mem_w_en  in  1  control bits
stall_o  out  1  hold PC and IF/ID this cycle
exe_valid, exe_pc, exe_src1, exe_src2, exe_st_src, exe_dest, exe_val1, exe_val2, exe_st_val, exe_cmd, exe_wb_en, exe_mem_r_en, exe_mem_w_en  out  (widths as ID counterparts)  registered stage contents
bubble_cnt  out  CNT_W  saturating count of load-use bubbles

Behaviour:
- Bubble definition: every exe_* output is 0.
- Reset: every exe_* output, stall_o and bubble_cnt are 0.
- Latency: one cycle, ID to exe_*.
- Hazard term, combinational from registered state and ID inputs:
  hz = exe_valid & exe_mem_r_en & exe_wb_en & (exe_dest != 0) & id_valid & ((id_uses_src1 & id_src1==exe_dest) | (id_uses_src2 & id_src2==exe_dest) | (id_uses_st & id_st_src==exe_dest))
- stall_o = hz & ~freeze & ~flush.
- Next-state priority, highest first:
  1. rst: bubble; bubble_cnt <= 0.
  2. flush: load bubble; flush overrides freeze; counter unchanged.
  3. freeze: all registers hold, including bubble_cnt.
  4. hz: load bubble; bubble_cnt += 1, saturating at all ones.
  5. Otherwise: load the ID fields. If id_valid is 0, load a bubble instead.
- A load-use hazard costs exactly one bubble. After the bubble, exe_mem_r_en is 0, so hz drops and the held ID instruction enters EXE on the next non-frozen cycle.
- Register 0 never creates a hazard. A load whose exe_wb_en is 0 never creates a hazard.
- Freeze asserted while hz is true: stall_o is 0 (the top-level freeze already holds upstream). The hazard is re-evaluated after freeze releases.
- Flush and hz in the same cycle: flush wins, stall_o is 0, counter unchanged.
- Reset mid-stall: the next cycle is a bubble with stall_o 0.

Decomposition:
- Shared package pipe_pkg:
  - DATA_W/REG_W/CMD_W constants
  - EXE_CMD encodings
  - packed struct id_exe_t holding all stage fields
  - BUBBLE constant (all zero)
- One natural sub-module: load_use_detect, purely combinational, computes hz. The register, priority mux and counter stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles while the ID inputs are nonzero -> all exe_* = 0, stall_o = 0, bubble_cnt = 0.
- Pass-through: non-hazard ID add (src1=3, src2=4, dest=5, val1=0x10, val2=0x20) -> one cycle later exe_* match the inputs exactly; stall_o stays 0.
- Load-use: load r7 in EXE (mem_r_en=1, wb_en=1), ID add with src2=7, uses_src2=1:
  - stall_o=1 in that cycle
  - next cycle exe_* all 0, bubble_cnt=1
  - following cycle the add enters with exe_src2=7
- Store data: load r9, ID store with st_src=9, uses_st=1 -> one bubble. A load of r0 followed by a use of r0 -> no bubble.
- Priority checks:
  - freeze held 3 cycles during a hazard -> exe_* frozen, stall_o=0; after release, stall_o=1 and one bubble.
  - flush together with a hazard -> bubble, stall_o=0, counter unchanged.
- Saturation: with CNT_W=2, force 5 hazards -> bubble_cnt reads 3 and stays at 3.
